// File: rtl/demux_sel_ctrl.sv
// Lane selector feeding a 1:2 demux: alternates lanes, steers around paused lanes.
// Optional per-lane accepted-word counters (cnt0/cnt1) are built only when SEL_CTRL_CNT_EN is defined.
module demux_sel_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              validIn,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              pause0,
  input  logic              pause1,
  output logic              readyOut,
  output logic [DATA_W-1:0] dataOut,
  output logic              validOut,
  output logic              selector,
  output logic [1:0]        state
`ifdef SEL_CTRL_CNT_EN
  ,
  output logic [7:0]        cnt0,
  output logic [7:0]        cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SEND0 = 2'b01,
    SEND1 = 2'b10,
    STALL = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic                sel_q;
  logic                nxt_q;
  logic                both_paused;
  logic                accept;
  logic                chosen;

  assign both_paused = pause0 & pause1;
  assign readyOut    = ~both_paused;
  assign accept      = validIn & readyOut;

  // Preferred lane unless it is paused; readyOut guarantees the other one is free.
  assign chosen = (nxt_q ? pause1 : pause0) ? ~nxt_q : nxt_q;

  always_comb begin
    state_d = IDLE;
    if (accept) begin
      state_d = chosen ? SEND1 : SEND0;
    end else if (validIn && both_paused) begin
      state_d = STALL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
      nxt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= accept;
      if (accept) begin
        data_q <= dataIn;
        sel_q  <= chosen;
        nxt_q  <= ~chosen;
      end
    end
  end

`ifdef SEL_CTRL_CNT_EN
  logic [7:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else if (accept) begin
      if (chosen) cnt1_q <= cnt1_q + 8'd1;
      else        cnt0_q <= cnt0_q + 8'd1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

  assign dataOut  = data_q;
  assign validOut = valid_q;
  assign selector = sel_q;
  assign state    = state_q;

endmodule

// File: tb/tb_demux_sel_ctrl.sv
// Randomized self-checking bench for demux_sel_ctrl against a lane-choice model.
// Define SEL_CTRL_CNT_EN for both files to exercise the counters.
module tb_demux_sel_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       validIn = 1'b0;
  logic [7:0] dataIn = 8'h00;
  logic       pause0 = 1'b0;
  logic       pause1 = 1'b0;
  logic       readyOut;
  logic [7:0] dataOut;
  logic       validOut;
  logic       selector;
  logic [1:0] state;
`ifdef SEL_CTRL_CNT_EN
  logic [7:0] cnt0, cnt1;
`endif

  demux_sel_ctrl #(.DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .validIn  (validIn),
    .dataIn   (dataIn),
    .pause0   (pause0),
    .pause1   (pause1),
    .readyOut (readyOut),
    .dataOut  (dataOut),
    .validOut (validOut),
    .selector (selector),
    .state    (state)
`ifdef SEL_CTRL_CNT_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: preferred lane, expected registered outputs
  logic       m_nxt   = 1'b0;
  logic [7:0] e_data  = 8'h00;
  logic       e_valid = 1'b0;
  logic       e_sel   = 1'b0;
  logic [1:0] e_state = 2'd0;
  int         e_cnt0  = 0;
  int         e_cnt1  = 0;
  logic [7:0] sb_q[$];

  function automatic logic [11:0] exp_vec();
    return {e_valid, e_sel, e_state, e_data};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {validOut, selector, state, dataOut};
  endfunction

  task automatic model_reset();
    m_nxt = 1'b0; e_data = 8'h00; e_valid = 1'b0; e_sel = 1'b0; e_state = 2'd0;
    e_cnt0 = 0; e_cnt1 = 0;
  endtask

  // Apply one cycle of stimulus and advance the model by the spec's lane rules.
  task automatic drive(input logic v, input logic [7:0] d, input logic p0, input logic p1);
    logic lane;
    @(negedge clk);
    validIn = v; dataIn = d; pause0 = p0; pause1 = p1;
    @(posedge clk);
    #1;
    if (v && !(p0 && p1)) begin
      if (m_nxt == 1'b0) lane = p0 ? 1'b1 : 1'b0;
      else               lane = p1 ? 1'b0 : 1'b1;
      e_data = d; e_valid = 1'b1; e_sel = lane; m_nxt = !lane;
      e_state = lane ? 2'd2 : 2'd1;
      if (lane) e_cnt1 = (e_cnt1 + 1) % 256;
      else      e_cnt0 = (e_cnt0 + 1) % 256;
    end else begin
      e_valid = 1'b0;
      e_state = (v && p0 && p1) ? 2'd3 : 2'd0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    validIn = 1'b0; pause0 = 1'b0; pause1 = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (dut_vec() !== 12'h000) $display("FAIL reset_outputs got %h want %h", dut_vec(), 12'h000);
    else n_pass++;
`ifdef SEL_CTRL_CNT_EN
    n_checks++;
    if ({cnt0, cnt1} !== 16'h0000) $display("FAIL reset_counters got %h want 0000", {cnt0, cnt1});
    else n_pass++;
`endif
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_round_robin();
    logic [7:0] words[4];
    logic       sels[4];
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    sels  = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, words[i], 1'b0, 1'b0);
      n_checks++;
      if (dut_vec() !== exp_vec() || selector !== sels[i] || dataOut !== words[i])
        $display("FAIL round_robin[%0d] got %h want %h", i, dut_vec(), {1'b1, sels[i], sels[i] ? 2'd2 : 2'd1, words[i]});
      else n_pass++;
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (validOut !== 1'b0 || state !== 2'd0) $display("FAIL round_robin_end got v=%b st=%0d want v=0 st=0", validOut, state);
    else n_pass++;
  endtask

  task automatic test_pause0();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0);
      n_checks++;
      if (dut_vec() !== exp_vec() || selector !== 1'b1)
        $display("FAIL pause0_redirect[%0d] got %h want %h", i, dut_vec(), exp_vec());
      else n_pass++;
    end
    drive(1'b1, 8'hCF, 1'b0, 1'b0);
    n_checks++;
    if (selector !== 1'b0 || dut_vec() !== exp_vec())
      $display("FAIL pause0_nxt_kept got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_stall();
    drive(1'b1, 8'h5A, 1'b1, 1'b1);
    n_checks++;
    if (readyOut !== 1'b0 || state !== 2'd3 || validOut !== 1'b0)
      $display("FAIL stall got rdy=%b st=%0d v=%b want rdy=0 st=3 v=0", readyOut, state, validOut);
    else n_pass++;
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    n_checks++;
    if (dataOut !== 8'hA5 || selector !== 1'b1 || dut_vec() !== exp_vec())
      $display("FAIL stall_release got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'($urandom), 1'b0, 1'b0);
      n_checks++;
      if (dut_vec() !== exp_vec() || dataOut !== 8'hA5)
        $display("FAIL idle_hold[%0d] got %h want %h", i, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    drive(1'b1, 8'h3D, 1'b0, 1'b0);
    #2 reset = 1'b1;
    pause0 = 1'b1; pause1 = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (dut_vec() !== 12'h000) $display("FAIL async_reset got %h want 000", dut_vec());
    else n_pass++;
    n_checks++;
    if (readyOut !== 1'b1) $display("FAIL reset_ready got %b want 1", readyOut);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (validOut !== 1'b0 || state !== 2'd0) $display("FAIL reset_no_accept got v=%b st=%0d want 0 0", validOut, state);
    else n_pass++;
    @(negedge clk);
    validIn = 1'b0; pause0 = 1'b0;
    reset = 1'b0;
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    n_checks++;
    if (selector !== 1'b0 || dut_vec() !== exp_vec())
      $display("FAIL post_reset_lane got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  // Upstream holds a refused word; the scoreboard catches drops and duplicates.
  task automatic test_random();
    logic       pend_v = 1'b0;
    logic [7:0] pend_d = 8'h00;
    logic       p0, p1;
    int         errs = 0;
    apply_reset();
    sb_q.delete();
    for (int i = 0; i < 400; i++) begin
      if (!pend_v) begin
        pend_v = ($urandom_range(0, 9) < 7);
        pend_d = 8'($urandom);
        if (pend_v) sb_q.push_back(pend_d);
      end
      p0 = ($urandom_range(0, 9) < 4);
      p1 = ($urandom_range(0, 9) < 4);
      drive(pend_v, pend_d, p0, p1);
      if (pend_v && !(p0 && p1)) pend_v = 1'b0;
      n_checks++;
      if (dut_vec() !== exp_vec() || readyOut !== !(p0 && p1)) begin
        $display("FAIL random[%0d] got %h rdy=%b want %h rdy=%b", i, dut_vec(), readyOut, exp_vec(), !(p0 && p1));
        errs++;
      end else n_pass++;
      if (validOut === 1'b1) begin
        n_checks++;
        if (sb_q.size() == 0 || dataOut !== sb_q[0])
          $display("FAIL random_order[%0d] got %h want %h", i, dataOut, sb_q.size() ? sb_q[0] : 8'hxx);
        else n_pass++;
        if (sb_q.size() != 0) void'(sb_q.pop_front());
      end
`ifdef SEL_CTRL_CNT_EN
      n_checks++;
      if (cnt0 !== 8'(e_cnt0) || cnt1 !== 8'(e_cnt1))
        $display("FAIL random_cnt[%0d] got %0d/%0d want %0d/%0d", i, cnt0, cnt1, e_cnt0, e_cnt1);
      else n_pass++;
`endif
    end
  endtask

`ifdef SEL_CTRL_CNT_EN
  task automatic test_counters();
    apply_reset();
    for (int i = 0; i < 257; i++) drive(1'b1, 8'(i), 1'b0, 1'b1);
    n_checks++;
    if (cnt0 !== 8'd1 || cnt1 !== 8'd0 || cnt0 !== 8'(e_cnt0))
      $display("FAIL cnt_wrap got %0d/%0d want 1/0", cnt0, cnt1);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_pause0();
    test_stall();
    test_idle_hold();
    test_async_reset();
    test_random();
`ifdef SEL_CTRL_CNT_EN
    test_counters();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_sel_ctrl.md
DEMUX_SEL_CTRL -- requirements
Module: demux_sel_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits; every width below written as DATA_W is this parameter.
REQ-002 clk  input  1  single clock; all flops rising-edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 validIn  input  1  upstream word valid.
REQ-005 dataIn  input  DATA_W  upstream data word.
REQ-006 pause0  input  1  lane-0 downstream almost-full; lane 0 SHALL NOT be chosen while high.
REQ-007 pause1  input  1  lane-1 downstream almost-full; lane 1 SHALL NOT be chosen while high.
REQ-008 readyOut  output  1  combinational; high when a word offered this cycle is accepted.
REQ-009 dataOut  output  DATA_W  registered word driving the 1:2 demux data input.
REQ-010 validOut  output  1  registered valid driving the demux validIn.
REQ-011 selector  output  1  registered lane select driving the demux selector: 0 = lane 0, 1 = lane 1.
REQ-012 state  output  2  current FSM state, for debug.
REQ-013 cnt0, cnt1  output  8 each  per-lane accepted-word counters; present only under SEL_CTRL_CNT_EN.

Function
REQ-014 readyOut SHALL equal NOT(pause0 AND pause1), independent of validIn.
REQ-015 Accept SHALL occur when validIn AND readyOut are high in the same cycle.
REQ-016 An internal pointer nxt (1 bit) SHALL name the preferred lane for the next accepted word.
REQ-017 Chosen lane on accept SHALL be nxt if that lane is not paused, otherwise the other lane.
REQ-018 On accept, at the next edge: dataOut<=dataIn, validOut<=1, selector<=chosen, nxt<=NOT chosen.
REQ-019 Without accept: validOut<=0; dataOut, selector and nxt SHALL hold.
REQ-020 Latency SHALL be exactly 1 cycle from an accepted input to validOut.
REQ-021 Sustained throughput SHALL be 1 word/cycle while at least one lane is unpaused.
REQ-022 FSM states: IDLE=2'b00, SEND0=2'b01, SEND1=2'b10, STALL=2'b11.
REQ-023 Next state SHALL be SEND0 or SEND1 on accept, by chosen lane.
REQ-024 Next state SHALL be STALL when validIn=1 and both lanes are paused.
REQ-025 Next state SHALL be IDLE in all other cases; transitions are legal from any state.
REQ-026 Pause SHALL be sampled in the cycle of accept; a pause asserting the same cycle as an accept to that lane redirects that accept.
REQ-027 A word refused in STALL SHALL be held by the upstream until readyOut rises; no data is dropped or duplicated.

Reset
REQ-028 While reset=1, immediately and independent of clk: dataOut=0, validOut=0, selector=0, nxt=0, state=IDLE, cnt0=cnt1=0.
REQ-029 Reset mid-stream SHALL discard any in-flight output word; the first accept after release goes to lane 0 if unpaused.
REQ-030 readyOut SHALL follow REQ-014 during reset; no accept is registered while reset=1.

Configuration
REQ-031 Macro SEL_CTRL_CNT_EN defined: cnt0/cnt1 SHALL increment by 1 on each accept to their lane, wrapping 255->0.
REQ-032 Macro SEL_CTRL_CNT_EN undefined: cnt0/cnt1 ports and logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset, then validIn=1 for 4 cycles with data 0x11,0x22,0x33,0x44 and no pause -> selector 0,1,0,1; validOut high for 4 cycles starting 1 cycle later.
REQ-034 pause0=1 held, 3 words offered -> all three go to selector=1; nxt remains 0 after each accept.
REQ-035 pause0=pause1=1 with validIn=1 -> readyOut=0, state=STALL, validOut=0; drop pause1 with word 0xA5 -> next cycle dataOut=0xA5, selector=1.
REQ-036 Assert reset asynchronously mid-burst -> outputs 0 and state IDLE within the same cycle; first word after release -> selector=0.
REQ-037 With SEL_CTRL_CNT_EN, 257 accepts to lane 0 (pause1=1) -> cnt0=1, cnt1=0.
REQ-038 validIn=0 with no pause -> state=IDLE, validOut=0, dataOut holds last value.
